// File: rtl/dsp_result_collector.sv
// Result collector behind a pipelined DSP slice: tracks in-flight ops, captures/scales P, buffers in a credit-guarded FIFO.
// Optional saturation is enabled by defining DSP_RESULT_COLLECTOR_SAT_EN (default build truncates).
module dsp_result_collector #(
  parameter int PIPE_DEPTH = 2,
  parameter int SHIFT      = 0,
  parameter int OUT_WIDTH  = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [47:0]                     p_i,
  input  logic                            carryout_i,
  output logic [OUT_WIDTH-1:0]            dout_o,
  output logic                            dout_carry_o,
  output logic                            dout_valid_o,
  input  logic                            dout_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]     level_o,
  output logic                            sat_flag_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [PIPE_DEPTH-1:0] inflight_q, inflight_d;
  logic [OUT_WIDTH:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         level_q, level_d, credits_q, credits_d;
  logic                  accept, capture, pop;
  logic [OUT_WIDTH-1:0]  scaled;
  logic                  sat_hit;

  assign accept  = issue_valid_i && (credits_q != '0);
  assign capture = inflight_q[PIPE_DEPTH-1];
  assign pop     = dout_ready_i && (level_q != '0);

  generate
    if (PIPE_DEPTH == 1) begin : g_pipe1
      assign inflight_d = accept;
    end else begin : g_pipen
      assign inflight_d = {inflight_q[PIPE_DEPTH-2:0], accept};
    end
  endgenerate

`ifdef DSP_RESULT_COLLECTOR_SAT_EN
  logic signed [47:0] s;
  assign s = $signed(p_i) >>> SHIFT;
  generate
    if (OUT_WIDTH == 48) begin : g_nosat
      assign sat_hit = 1'b0;
      assign scaled  = s[OUT_WIDTH-1:0];
    end else begin : g_sat
      // In range only if every bit from the sign bit of the result upward matches.
      logic [48-OUT_WIDTH:0] top;
      assign top     = s[47:OUT_WIDTH-1];
      assign sat_hit = !((&top) || !(|top));
      assign scaled  = !sat_hit ? s[OUT_WIDTH-1:0] :
                       s[47]    ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  endgenerate
`else
  assign sat_hit = 1'b0;
  assign scaled  = OUT_WIDTH'($signed(p_i) >>> SHIFT);
`endif

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    credits_d = credits_q;
    if (capture) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    level_d   = level_q + CW'(capture) - CW'(pop);
    credits_d = credits_q - CW'(accept) + CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      credits_q  <= CW'(FIFO_DEPTH);
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      credits_q  <= credits_d;
      if (capture) mem_q[wr_ptr_q] <= {carryout_i, scaled};
    end
  end

`ifdef DSP_RESULT_COLLECTOR_SAT_EN
  logic sat_flag_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)                  sat_flag_q <= 1'b0;
    else if (capture && sat_hit) sat_flag_q <= 1'b1;
  end
  assign sat_flag_o = sat_flag_q;
`else
  assign sat_flag_o = 1'b0;
`endif

  assign issue_ready_o = (credits_q != '0);
  assign dout_o        = mem_q[rd_ptr_q][OUT_WIDTH-1:0];
  assign dout_carry_o  = mem_q[rd_ptr_q][OUT_WIDTH];
  assign dout_valid_o  = (level_q != '0);
  assign level_o       = level_q;
endmodule

// File: tb/tb_dsp_result_collector.sv
// Bench for dsp_result_collector: slice model feeds P, scoreboard checks every popped result in issue order.
module tb_dsp_result_collector;
  logic        clk = 1'b0, rst = 1'b1, issue_valid = 1'b0, op_c = 1'b0, dout_ready = 1'b0;
  logic [47:0] op_p = '0;
  logic [48:0] st0 = '0, st1 = '0;
  logic        issue_ready, dout_carry, dout_valid, sat_flag;
  logic [23:0] dout;
  logic [2:0]  level;
  logic [24:0] sb[$];
  int          n_cmp = 0, n_err = 0;

  dsp_result_collector #(.PIPE_DEPTH(2), .SHIFT(4), .OUT_WIDTH(24), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .p_i(st1[47:0]), .carryout_i(st1[48]), .dout_o(dout), .dout_carry_o(dout_carry),
    .dout_valid_o(dout_valid), .dout_ready_i(dout_ready), .level_o(level), .sat_flag_o(sat_flag));

  always #5 clk = ~clk;

  // Two-register slice model: operand presented at issue edge N appears on P for edge N+2.
  always @(posedge clk) begin
    st0 <= {op_c, op_p};
    st1 <= st0;
  end

  function automatic logic [23:0] exp_scale(input logic [47:0] p);
    logic signed [47:0] s;
    s = $signed(p) >>> 4;
`ifdef DSP_RESULT_COLLECTOR_SAT_EN
    if (s > 48'sd8388607)  return 24'h7FFFFF;
    if (s < -48'sd8388608) return 24'h800000;
`endif
    return s[23:0];
  endfunction

  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (issue_valid && issue_ready) sb.push_back({op_c, exp_scale(op_p)});
      if (dout_valid && dout_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL sb_pop: got %h with nothing expected", {dout_carry, dout});
        end else begin
          logic [24:0] e;
          e = sb.pop_front();
          if ({dout_carry, dout} !== e) begin
            n_err++; $display("FAIL sb_data: got %h expected %h", {dout_carry, dout}, e);
          end
        end
      end
      n_cmp++;
      if (level > 3'd4) begin n_err++; $display("FAIL level_bound: got %0d max 4", level); end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue_one(input logic [47:0] p, input logic c);
    issue_valid = 1'b1; op_p = p; op_c = c;
    tick(1);
    issue_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; issue_valid = 1'b1; op_p = 48'h1; dout_ready = 1'b0;
    tick(3);
    rst = 1'b0; issue_valid = 1'b0;
    n_cmp++; if (level !== 3'd0)      begin n_err++; $display("FAIL rst_level: got %0d exp 0", level); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", dout_valid); end
    n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b exp 1", issue_ready); end
    n_cmp++; if ({dout_carry, dout} !== 25'h0) begin n_err++; $display("FAIL rst_dout: got %h exp 0", {dout_carry, dout}); end
    n_cmp++; if (sat_flag !== 1'b0)   begin n_err++; $display("FAIL rst_sat: got %b exp 0", sat_flag); end
    tick(4);
    n_cmp++; if (dout_valid !== 1'b0 || level !== 3'd0) begin
      n_err++; $display("FAIL rst_nocapture: valid %b level %0d exp 0/0", dout_valid, level); end
  endtask

  task automatic test_latency;
    dout_ready = 1'b0;
    issue_one(48'd19744, 1'b1);  // 1234 << 4
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL lat_n0: valid %b exp 0", dout_valid); end
    tick(1);
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL lat_n1: valid %b exp 0", dout_valid); end
    tick(1);
    n_cmp++; if (dout_valid !== 1'b1 || dout !== 24'd1234 || dout_carry !== 1'b1 || level !== 3'd1) begin
      n_err++; $display("FAIL lat_n2: valid %b dout %0d carry %b level %0d exp 1/1234/1/1",
                        dout_valid, dout, dout_carry, level); end
    dout_ready = 1'b1; tick(1); dout_ready = 1'b0;
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL lat_drain: level %0d exp 0", level); end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      issue_valid = 1'b1; op_p = 48'($urandom_range(0, 1 << 20)) << 3; op_c = i[0];
      if (issue_ready) acc++;
      tick(1);
    end
    issue_valid = 1'b0;
    tick(3);
    n_cmp++; if (acc != 4) begin n_err++; $display("FAIL bp_accepted: got %0d exp 4", acc); end
    n_cmp++; if (issue_ready !== 1'b0 || level !== 3'd4) begin
      n_err++; $display("FAIL bp_full: ready %b level %0d exp 0/4", issue_ready, level); end
    dout_ready = 1'b1; tick(1); dout_ready = 1'b0;
    n_cmp++; if (issue_ready !== 1'b1 || level !== 3'd3) begin
      n_err++; $display("FAIL bp_pop: ready %b level %0d exp 1/3", issue_ready, level); end
  endtask

  task automatic test_full_rw;
    issue_one(48'h0000_0000_ABC0, 1'b0);
    tick(1);
    dout_ready = 1'b1; tick(1); dout_ready = 1'b0;  // capture and pop on the same edge
    n_cmp++; if (level !== 3'd3 || issue_ready !== 1'b1) begin
      n_err++; $display("FAIL rw_same_edge: level %0d ready %b exp 3/1", level, issue_ready); end
    issue_one(-48'sd4096, 1'b1);
    tick(2);
    n_cmp++; if (level !== 3'd4 || issue_ready !== 1'b0) begin
      n_err++; $display("FAIL rw_full: level %0d ready %b exp 4/0", level, issue_ready); end
  endtask

  task automatic test_back_to_back;
    dout_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue_valid = 1'b1; op_p = 48'(i * 7919) << 4; op_c = i[1];
      tick(1);
    end
    issue_valid = 1'b0;
    tick(6);
    dout_ready = 1'b0;
    n_cmp++; if (level !== 3'd0 || sb.size() != 0) begin
      n_err++; $display("FAIL b2b_drain: level %0d pending %0d exp 0/0", level, sb.size()); end
  endtask

  task automatic test_scaling;
    logic exp_sat;
    dout_ready = 1'b0;
    issue_one(-48'sd160, 1'b0); tick(2);
    n_cmp++; if (dout !== 24'hFFFFF6 || sat_flag !== 1'b0) begin
      n_err++; $display("FAIL scale_neg: dout %h sat %b exp FFFFF6/0", dout, sat_flag); end
    dout_ready = 1'b1; tick(1); dout_ready = 1'b0;
`ifdef DSP_RESULT_COLLECTOR_SAT_EN
    exp_sat = 1'b1;
`else
    exp_sat = 1'b0;
`endif
    issue_one(48'h0000_1000_0000, 1'b0); tick(2);
    n_cmp++; if (dout !== (exp_sat ? 24'h7FFFFF : 24'h000000) || sat_flag !== exp_sat) begin
      n_err++; $display("FAIL scale_pos_ovf: dout %h sat %b exp_sat %b", dout, sat_flag, exp_sat); end
    dout_ready = 1'b1; tick(1); dout_ready = 1'b0;
    issue_one(-48'sh0000_1000_0000, 1'b1); tick(2);
    n_cmp++; if (dout !== (exp_sat ? 24'h800000 : 24'h000000) || dout_carry !== 1'b1) begin
      n_err++; $display("FAIL scale_neg_ovf: dout %h carry %b exp_sat %b", dout, dout_carry, exp_sat); end
    dout_ready = 1'b1; tick(1); dout_ready = 1'b0;
    issue_one(48'd160, 1'b0); tick(2);
    n_cmp++; if (dout !== 24'h00000A || sat_flag !== exp_sat) begin
      n_err++; $display("FAIL scale_sticky: dout %h sat %b exp 00000A/%b", dout, sat_flag, exp_sat); end
    dout_ready = 1'b1; tick(1); dout_ready = 1'b0;
  endtask

  task automatic test_midop_reset;
    int acc = 0;
    dout_ready = 1'b0;
    issue_one(48'h100, 1'b0); issue_one(48'h200, 1'b1); tick(2);
    issue_one(48'h300, 1'b0); issue_one(48'h400, 1'b1);
    n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL mid_pre: level %0d exp 2", level); end
    rst = 1'b1; tick(1); rst = 1'b0;
    n_cmp++; if (level !== 3'd0 || dout_valid !== 1'b0 || issue_ready !== 1'b1 || sat_flag !== 1'b0) begin
      n_err++; $display("FAIL mid_rst: level %0d valid %b ready %b sat %b exp 0/0/1/0",
                        level, dout_valid, issue_ready, sat_flag); end
    tick(4);
    n_cmp++; if (level !== 3'd0 || dout_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_stale: level %0d valid %b exp 0/0", level, dout_valid); end
    for (int i = 0; i < 6; i++) begin
      issue_valid = 1'b1; op_p = 48'(i + 1) << 4; op_c = 1'b0;
      if (issue_ready) acc++;
      tick(1);
    end
    issue_valid = 1'b0;
    n_cmp++; if (acc != 4) begin n_err++; $display("FAIL mid_credits: got %0d exp 4", acc); end
    tick(3);
    dout_ready = 1'b1; tick(5); dout_ready = 1'b0;
    n_cmp++; if (level !== 3'd0 || sb.size() != 0) begin
      n_err++; $display("FAIL mid_drain: level %0d pending %0d exp 0/0", level, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_full_rw();
    test_back_to_back();
    test_scaling();
    test_midop_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
